// File: rtl/uart_alu_ctrl.sv
// Sequencer between the UART receiver, the ALU and the UART transmitter.
// Collects A, B and opcode bytes, runs the ALU, hands the result to the transmitter.
module uart_alu_ctrl #(
  parameter int DBIT        = 8,
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_data,
  input  logic [DBIT-1:0] alu_result,
  input  logic            tx_done_tick,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [OP_W-1:0] alu_op,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_data,
  output logic            busy,
  output logic            overrun,
  output logic            timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   timer, timer_n, timer_sat;
  logic [DBIT-1:0] a_n, b_n, res_n;
  logic [OP_W-1:0] op_n;
  logic            expiry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= GET_A;
      timer   <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      tx_data <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      alu_a   <= a_n;
      alu_b   <= b_n;
      alu_op  <= op_n;
      tx_data <= res_n;
    end
  end

  // The timer never wraps; a byte landing on the expiry cycle beats the abort.
  assign timer_sat = (timer == T_LAST) ? timer : timer + 1'b1;
  assign expiry    = (timer == T_LAST) && !rx_done_tick;

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    a_n      = alu_a;
    b_n      = alu_b;
    op_n     = alu_op;
    res_n    = tx_data;
    tx_start = 1'b0;
    timeout  = 1'b0;
    busy     = 1'b0;
    unique case (state)
      GET_A: begin
        if (rx_done_tick) begin
          a_n     = rx_data;
          timer_n = '0;
          state_n = GET_B;
        end
      end
      GET_B: begin
        if (rx_done_tick) begin
          b_n     = rx_data;
          timer_n = '0;
          state_n = GET_OP;
        end else if (expiry) begin
          timeout = 1'b1;
          state_n = GET_A;
        end else begin
          timer_n = timer_sat;
        end
      end
      GET_OP: begin
        if (rx_done_tick) begin
          op_n    = rx_data[OP_W-1:0];
          state_n = EXEC;
        end else if (expiry) begin
          timeout = 1'b1;
          state_n = GET_A;
        end else begin
          timer_n = timer_sat;
        end
      end
      EXEC: begin
        busy    = 1'b1;
        res_n   = alu_result;
        state_n = SEND;
      end
      SEND: begin
        busy     = 1'b1;
        tx_start = 1'b1;
        state_n  = WAIT_TX;
      end
      WAIT_TX: begin
        busy = 1'b1;
        if (tx_done_tick) state_n = GET_A;
      end
      default: state_n = GET_A;
    endcase
  end

  assign overrun = busy && rx_done_tick;

endmodule
